bus_demux_regfile: RTL and testbench

//   Write side of the datapath bus. Takes one word from the shared bus and loads it

---
 rtl/bus_demux_regfile_pkg.sv | 19 +
 rtl/bus_demux_regfile_dest_decoder.sv | 18 +
 rtl/bus_demux_regfile.sv | 106 ++++++++++
 tb/tb_bus_demux_regfile.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_demux_regfile_pkg.sv
// Shared constants and types for the bus write-side register file.
// Destination codes are laid out as: GPRs first, then HI, LO and the HI:LO pair.
package bus_demux_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 5;
    localparam int R0_ZERO  = 1;

    localparam int DEST_HI   = NUM_REGS;
    localparam int DEST_LO   = NUM_REGS + 1;
    localparam int DEST_PAIR = NUM_REGS + 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PAIR_HI = 1'b1
    } state_e;

endpackage

// File: rtl/bus_demux_regfile_dest_decoder.sv
// Combinational destination decoder: binary dest code to one-hot enables.
// Any code outside the one-hot range raises illegal_o and leaves every enable low.
module bus_demux_regfile_dest_decoder #(
    parameter int SEL_W    = 5,
    parameter int NUM_DEST = 19
) (
    input  logic [SEL_W-1:0]    dest_sel_i,
    output logic [NUM_DEST-1:0] onehot_o,
    output logic                illegal_o
);

    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dec
        assign onehot_o[gi] = (dest_sel_i == SEL_W'(gi));
    end

    assign illegal_o = ~|onehot_o;

endmodule

// File: rtl/bus_demux_regfile.sv
// Bus write side: loads one bus word per beat into a GPR, HI or LO, and
// accepts a 64-bit HI:LO result as two beats (LO first, then HI).
module bus_demux_regfile #(
    parameter int DATA_W   = bus_demux_regfile_pkg::DATA_W,
    parameter int NUM_REGS = bus_demux_regfile_pkg::NUM_REGS,
    parameter int SEL_W    = bus_demux_regfile_pkg::SEL_W,
    parameter int R0_ZERO  = bus_demux_regfile_pkg::R0_ZERO
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           bus_in,
    input  logic [SEL_W-1:0]            dest_sel,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        wr_err,
    output logic                        pair_busy,
    input  logic [$clog2(NUM_REGS)-1:0] rd_sel,
    output logic [DATA_W-1:0]           rd_data,
    output logic [DATA_W-1:0]           hi_out,
    output logic [DATA_W-1:0]           lo_out
);
    import bus_demux_regfile_pkg::*;

    localparam int N_DEST = NUM_REGS + 3;
    localparam int IDX_HI = NUM_REGS;
    localparam int IDX_LO = NUM_REGS + 1;
    localparam int IDX_PR = NUM_REGS + 2;

    logic [N_DEST-1:0]   dest_onehot;
    logic                dest_illegal;
    logic                accept;
    logic                in_idle;
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   gpr_q [NUM_REGS];
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] gpr_we;
    logic                hi_we, lo_we;

    bus_demux_regfile_dest_decoder #(
        .SEL_W    (SEL_W),
        .NUM_DEST (N_DEST)
    ) u_dest_decoder (
        .dest_sel_i (dest_sel),
        .onehot_o   (dest_onehot),
        .illegal_o  (dest_illegal)
    );

    // Reset takes priority over a simultaneous beat, so rst also blocks acceptance.
    assign wr_ready = !rst;
    assign accept   = wr_valid && !rst;
    assign in_idle  = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && dest_onehot[IDX_PR]) state_d = PAIR_HI;
            PAIR_HI: if (accept)                        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The second beat of a pair always lands in HI regardless of dest_sel.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr_we
        if (R0_ZERO != 0 && gi == 0) begin : g_r0
            assign gpr_we[gi] = 1'b0;
        end else begin : g_rn
            assign gpr_we[gi] = accept && in_idle && dest_onehot[gi];
        end
    end

    assign hi_we = accept && (!in_idle || dest_onehot[IDX_HI]);
    assign lo_we = accept && in_idle && (dest_onehot[IDX_LO] || dest_onehot[IDX_PR]);
    assign err_d = accept && in_idle && dest_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (gpr_we[i]) gpr_q[i] <= bus_in;
            end
            if (hi_we) hi_q <= bus_in;
            if (lo_we) lo_q <= bus_in;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        rd_data = gpr_q[rd_sel];
        if (R0_ZERO != 0 && rd_sel == '0) rd_data = '0;
    end

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign wr_err    = err_q;
    assign pair_busy = (state_q == PAIR_HI);

endmodule

// File: tb/tb_bus_demux_regfile.sv
// Scoreboard bench for bus_demux_regfile: a behavioural model predicts each cycle's
// register state, the prediction is queued at drive time and compared after the edge.
module tb_bus_demux_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] bus_in;
    logic [4:0]  dest_sel;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_err;
    logic        pair_busy;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    bus_demux_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .dest_sel  (dest_sel),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_err    (wr_err),
        .pair_busy (pair_busy),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        err;
        logic [3:0]  rsel;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_err;

    function automatic logic [31:0] m_read(input logic [3:0] rs);
        return (rs == 4'd0) ? 32'h0 : m_gpr[rs];
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [4:0] d, input logic [31:0] b);
        if (r) begin
            for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
            m_hi = 0; m_lo = 0; m_busy = 0; m_err = 0;
        end else begin
            m_err = 1'b0;
            if (v) begin
                if (m_busy) begin
                    m_hi = b; m_busy = 0;
                end else if (d < 5'd16) begin
                    if (d != 5'd0) m_gpr[d[3:0]] = b;
                end else if (d == 5'd16) m_hi = b;
                else if (d == 5'd17) m_lo = b;
                else if (d == 5'd18) begin
                    m_lo = b; m_busy = 1'b1;
                end else m_err = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive, check combinational outputs, predict, then compare after the edge.
    task automatic cycle(input string name, input logic r, input logic v,
                         input logic [4:0] d, input logic [31:0] b, input logic [3:0] rs);
        exp_t e;
        @(negedge clk);
        rst = r; wr_valid = v; dest_sel = d; bus_in = b; rd_sel = rs;
        #1;
        total++;
        if (wr_ready !== !r) begin
            bad++; $display("FAIL %s.wr_ready: got %b expected %b", name, wr_ready, !r);
        end
        total++;
        if (rd_data !== m_read(rs)) begin
            bad++; $display("FAIL %s.rd_pre_edge: got %h expected %h", name, rd_data, m_read(rs));
        end
        model_step(r, v, d, b);
        e.name = name; e.hi = m_hi; e.lo = m_lo; e.busy = m_busy; e.err = m_err;
        e.rsel = rs; e.rd = m_read(rs);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if (hi_out !== e.hi) begin
            bad++; $display("FAIL %s.hi_out: got %h expected %h", e.name, hi_out, e.hi);
        end
        total++;
        if (lo_out !== e.lo) begin
            bad++; $display("FAIL %s.lo_out: got %h expected %h", e.name, lo_out, e.lo);
        end
        total++;
        if (pair_busy !== e.busy) begin
            bad++; $display("FAIL %s.pair_busy: got %b expected %b", e.name, pair_busy, e.busy);
        end
        total++;
        if (wr_err !== e.err) begin
            bad++; $display("FAIL %s.wr_err: got %b expected %b", e.name, wr_err, e.err);
        end
        total++;
        if (rd_data !== e.rd) begin
            bad++; $display("FAIL %s.rd_data[%0d]: got %h expected %h", e.name, e.rsel, rd_data, e.rd);
        end
        $display("txn %s rst=%b v=%b dest=%0d bus=%h rd[%0d]=%h hi=%h lo=%h busy=%b err=%b",
                 e.name, r, v, d, b, rs, rd_data, hi_out, lo_out, pair_busy, wr_err);
    endtask

    task automatic check_all_gprs(input string name);
        for (int i = 0; i < 16; i++) cycle(name, 1'b0, 1'b0, 5'd0, 32'h0, 4'(i));
    endtask

    task automatic test_reset();
        cycle("reset", 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'd3);
        cycle("reset", 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'd3);
        cycle("reset_release", 1'b0, 1'b0, 5'd3, 32'h0, 4'd3);
    endtask

    task automatic test_gpr_write();
        cycle("gpr_write", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'd5);
        check_all_gprs("gpr_scan");
    endtask

    task automatic test_pair();
        cycle("pair_lo", 1'b0, 1'b1, 5'd18, 32'h1111_2222, 4'd7);
        for (int i = 0; i < 3; i++) cycle("pair_gap", 1'b0, 1'b0, 5'd18, 32'h0, 4'd7);
        cycle("pair_hi", 1'b0, 1'b1, 5'd7, 32'h3333_4444, 4'd7);
        cycle("pair_after", 1'b0, 1'b0, 5'd0, 32'h0, 4'd7);
        cycle("pair_bad_hi", 1'b0, 1'b1, 5'd18, 32'h0000_00AA, 4'd0);
        cycle("pair_bad_hi", 1'b0, 1'b1, 5'd27, 32'h0000_00BB, 4'd0);
    endtask

    task automatic test_illegal();
        cycle("illegal25", 1'b0, 1'b1, 5'd25, 32'h5, 4'd5);
        cycle("illegal_clear", 1'b0, 1'b0, 5'd25, 32'h5, 4'd5);
        cycle("illegal19", 1'b0, 1'b1, 5'd19, 32'h6, 4'd5);
        cycle("illegal31", 1'b0, 1'b1, 5'd31, 32'h7, 4'd5);
        cycle("illegal_clear", 1'b0, 1'b0, 5'd0, 32'h0, 4'd5);
        check_all_gprs("illegal_scan");
    endtask

    task automatic test_r0();
        cycle("r0_write", 1'b0, 1'b1, 5'd0, 32'h0000_ABCD, 4'd0);
        cycle("r0_read", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
    endtask

    task automatic test_same_cycle_rw();
        cycle("rw_same", 1'b0, 1'b1, 5'd9, 32'hCAFE_0001, 4'd9);
        cycle("rw_same", 1'b0, 1'b1, 5'd9, 32'hCAFE_0002, 4'd9);
        cycle("hi_lo", 1'b0, 1'b1, 5'd16, 32'h0BAD_F00D, 4'd9);
        cycle("hi_lo", 1'b0, 1'b1, 5'd17, 32'h600D_CAFE, 4'd15);
        cycle("r15", 1'b0, 1'b1, 5'd15, 32'h8765_4321, 4'd15);
    endtask

    task automatic test_reset_mid_pair();
        cycle("rmp_lo", 1'b0, 1'b1, 5'd18, 32'h9, 4'd5);
        cycle("rmp_rst", 1'b1, 1'b1, 5'd5, 32'h8, 4'd5);
        cycle("rmp_hi", 1'b0, 1'b1, 5'd16, 32'h0000_0077, 4'd5);
        cycle("rmp_idle", 1'b0, 1'b0, 5'd16, 32'h0, 4'd9);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            cycle("b2b", 1'b0, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  $urandom, 4'($urandom_range(0, 15)));
        end
        check_all_gprs("b2b_scan");
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; dest_sel = '0; bus_in = '0; rd_sel = '0;
        model_step(1'b1, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_gpr_write();
        test_pair();
        test_illegal();
        test_r0();
        test_same_cycle_rw();
        test_reset_mid_pair();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
